// File: rtl/game_pkg.sv
// game_pkg
// Shared types for the penalty simulator game controller.
//   game_state_t : screen-level state seen by screen_selector and drawing blocks
//   game_mode_t  : SOLO / MULTI, latched on an accepted start
//   seq_state_t  : internal sequencing state of match_sequencer
//   outcome_t    : result of the end-of-hold decision
package game_pkg;

    typedef enum logic [2:0] {
        START   = 3'd0,
        KEEPER  = 3'd1,
        SHOOTER = 3'd2,
        WINNER  = 3'd3,
        LOOSER  = 3'd4
    } game_state_t;

    typedef enum logic {
        SOLO  = 1'b0,
        MULTI = 1'b1
    } game_mode_t;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_PLAY  = 2'd1,
        S_HOLD  = 2'd2,
        S_END   = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        OUT_NEXT = 2'd0,
        OUT_WIN  = 2'd1,
        OUT_LOSE = 2'd2
    } outcome_t;

endpackage

// File: rtl/frame_hold_timer.sv
// frame_hold_timer
// Loadable down-counter advanced by frame_tick.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load count with load_val (wins over a simultaneous tick)
//   load_val  : reload value
//   tick      : decrement enable, one pulse per frame
//   done      : one-cycle pulse on the tick that takes the count from 1 to 0
// done is combinational so the caller can act on the very edge that
// samples the final tick.
module frame_hold_timer #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    assign done = tick && !load && (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/match_sequencer.sv
// match_sequencer
// Game controller: alternates shooter/keeper rounds, holds each shot
// result for a number of frames, resolves regulation and sudden death.
//   clk, rst       : clock, synchronous active-high reset
//   start_btn      : start / return-to-start pulse
//   mode_sel       : 0 SOLO, 1 MULTI, sampled on an accepted start
//   frame_tick     : one pulse per video frame
//   shot_resolved  : current shot finished (pulse)
//   shot_goal      : qualifies shot_resolved, 1 = goal
//   game_state     : START/KEEPER/SHOOTER/WINNER/LOOSER
//   game_mode      : latched mode
//   round_counter  : 0-based round, even = player shoots, odd = player keeps
//   score_player   : player goals (saturating)
//   score_opp      : opponent goals (saturating)
//   is_scored      : last shot was a goal, valid during the result hold
//   dbg_state      : internal sequencing state
// Input handshake: every control input is a single-cycle pulse with no
// back-pressure. A pulse is consumed on the edge that samples it if the
// current state accepts that input; otherwise it is silently dropped.
// All outputs are registered and change on the sampling edge.
module match_sequencer
    import game_pkg::*;
#(
    parameter int REG_ROUNDS  = 10,
    parameter int MAX_ROUNDS  = 30,
    parameter int HOLD_FRAMES = 90,
    parameter int ROUND_W     = 5,
    parameter int SCORE_W     = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_btn,
    input  logic               mode_sel,
    input  logic               frame_tick,
    input  logic               shot_resolved,
    input  logic               shot_goal,
    output game_state_t        game_state,
    output game_mode_t         game_mode,
    output logic [ROUND_W-1:0] round_counter,
    output logic [SCORE_W-1:0] score_player,
    output logic [SCORE_W-1:0] score_opp,
    output logic               is_scored,
    output seq_state_t         dbg_state
);

    // A zero hold would never produce a done pulse; hold at least one frame.
    localparam int HOLD_EFF = (HOLD_FRAMES < 1) ? 1 : HOLD_FRAMES;
    localparam int HOLD_W   = $clog2(HOLD_EFF + 1);

    seq_state_t         state, state_n;
    game_state_t        gs_n;
    game_mode_t         mode_n;
    logic [ROUND_W-1:0] round_n;
    logic [SCORE_W-1:0] sp_n, so_n;
    logic               sc_n;
    logic               timer_load;
    logic               hold_done;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Decision at the end of a hold. Regulation is only settled after a
    // keeper round (odd r) so both sides have had the same number of shots;
    // a tie at the hard cap is a loss.
    function automatic outcome_t decide_outcome(input logic [ROUND_W-1:0] r,
                                                input logic [SCORE_W-1:0] p,
                                                input logic [SCORE_W-1:0] o);
        int nr;
        nr = int'(r) + 1;
        if (nr < REG_ROUNDS) begin
            return OUT_NEXT;
        end else if (r[0] && (p != o)) begin
            return (p > o) ? OUT_WIN : OUT_LOSE;
        end else if (nr < MAX_ROUNDS) begin
            return OUT_NEXT;
        end else begin
            return OUT_LOSE;
        end
    endfunction

    frame_hold_timer #(
        .CNT_W(HOLD_W)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (HOLD_W'(HOLD_EFF)),
        .tick     (frame_tick && (state == S_HOLD)),
        .done     (hold_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_START;
            game_state    <= START;
            game_mode     <= MULTI;
            round_counter <= '0;
            score_player  <= '0;
            score_opp     <= '0;
            is_scored     <= 1'b0;
        end else begin
            state         <= state_n;
            game_state    <= gs_n;
            game_mode     <= mode_n;
            round_counter <= round_n;
            score_player  <= sp_n;
            score_opp     <= so_n;
            is_scored     <= sc_n;
        end
    end

    always_comb begin
        state_n    = state;
        gs_n       = game_state;
        mode_n     = game_mode;
        round_n    = round_counter;
        sp_n       = score_player;
        so_n       = score_opp;
        sc_n       = is_scored;
        timer_load = 1'b0;

        case (state)
            S_START: begin
                if (start_btn) begin
                    mode_n  = game_mode_t'(mode_sel);
                    sp_n    = '0;
                    so_n    = '0;
                    round_n = '0;
                    sc_n    = 1'b0;
                    gs_n    = SHOOTER;
                    state_n = S_PLAY;
                end
            end
            S_PLAY: begin
                // A tick in the same cycle is dropped: the hold starts here.
                if (shot_resolved) begin
                    sc_n = shot_goal;
                    if (shot_goal) begin
                        if (round_counter[0]) so_n = sat_inc(score_opp);
                        else                  sp_n = sat_inc(score_player);
                    end
                    timer_load = 1'b1;
                    state_n    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_done) begin
                    case (decide_outcome(round_counter, score_player, score_opp))
                        OUT_WIN: begin
                            gs_n    = WINNER;
                            state_n = S_END;
                        end
                        OUT_LOSE: begin
                            gs_n    = LOOSER;
                            state_n = S_END;
                        end
                        default: begin
                            round_n = round_counter + 1'b1;
                            sc_n    = 1'b0;
                            gs_n    = round_counter[0] ? SHOOTER : KEEPER;
                            state_n = S_PLAY;
                        end
                    endcase
                end
            end
            S_END: begin
                if (start_btn) begin
                    gs_n    = START;
                    state_n = S_START;
                end
            end
            default: begin
                state_n = S_START;
                gs_n    = START;
            end
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer
// Scripted games plus random traffic against a procedural reference model.
module tb_match_sequencer;
    import game_pkg::*;

    localparam int REG_ROUNDS  = 10;
    localparam int MAX_ROUNDS  = 12;
    localparam int HOLD_FRAMES = 5;
    localparam int ROUND_W     = 5;
    localparam int SCORE_W     = 5;
    localparam int W           = 3 + 1 + ROUND_W + 2 * SCORE_W + 1;
    localparam int SCORE_MAX   = (1 << SCORE_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_btn, mode_sel, frame_tick, shot_resolved, shot_goal;
    game_state_t        game_state;
    game_mode_t         game_mode;
    logic [ROUND_W-1:0] round_counter;
    logic [SCORE_W-1:0] score_player, score_opp;
    logic               is_scored;
    seq_state_t         dbg_state;

    match_sequencer #(
        .REG_ROUNDS (REG_ROUNDS),
        .MAX_ROUNDS (MAX_ROUNDS),
        .HOLD_FRAMES(HOLD_FRAMES),
        .ROUND_W    (ROUND_W),
        .SCORE_W    (SCORE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_btn    (start_btn),
        .mode_sel     (mode_sel),
        .frame_tick   (frame_tick),
        .shot_resolved(shot_resolved),
        .shot_goal    (shot_goal),
        .game_state   (game_state),
        .game_mode    (game_mode),
        .round_counter(round_counter),
        .score_player (score_player),
        .score_opp    (score_opp),
        .is_scored    (is_scored),
        .dbg_state    (dbg_state)
    );

    // ---------------- reference model ----------------
    // phase: 0 title screen, 1 waiting for a shot, 2 showing result, 3 game over
    int m_phase, m_round, m_sp, m_so, m_hold;
    bit m_mode, m_sc, m_win;

    function automatic logic [W-1:0] pack_exp();
        game_state_t gs;
        if (m_phase == 0)      gs = START;
        else if (m_phase == 3) gs = m_win ? WINNER : LOOSER;
        else                   gs = (m_round % 2 == 1) ? KEEPER : SHOOTER;
        return {gs, m_mode, ROUND_W'(m_round), SCORE_W'(m_sp), SCORE_W'(m_so), m_sc};
    endfunction

    task automatic model_step(input bit r, input bit sb, input bit ms,
                              input bit tk, input bit sr, input bit sg);
        if (r) begin
            m_phase = 0; m_mode = 1'b1; m_round = 0;
            m_sp = 0; m_so = 0; m_sc = 0; m_hold = 0; m_win = 0;
            return;
        end
        case (m_phase)
            0: if (sb) begin
                m_mode = ms; m_sp = 0; m_so = 0; m_round = 0; m_sc = 0;
                m_phase = 1;
            end
            1: if (sr) begin
                m_sc = sg;
                if (sg) begin
                    if (m_round % 2 == 0) m_sp = (m_sp < SCORE_MAX) ? m_sp + 1 : m_sp;
                    else                  m_so = (m_so < SCORE_MAX) ? m_so + 1 : m_so;
                end
                m_hold  = HOLD_FRAMES;
                m_phase = 2;
            end
            2: if (tk) begin
                m_hold--;
                if (m_hold == 0) begin
                    bit next_round;
                    next_round = 1'b1;
                    if (m_round + 1 >= REG_ROUNDS) begin
                        if (m_round % 2 == 1 && m_sp != m_so) begin
                            next_round = 1'b0; m_win = (m_sp > m_so);
                        end else if (m_sp == m_so && m_round + 1 >= MAX_ROUNDS) begin
                            next_round = 1'b0; m_win = 1'b0;
                        end
                    end
                    if (next_round) begin
                        m_round++; m_sc = 0; m_phase = 1;
                    end else begin
                        m_phase = 3;
                    end
                end
            end
            default: if (sb) m_phase = 0;
        endcase
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // ---------------- driver tasks ----------------
    task automatic drive_cycle(input bit r, input bit sb, input bit ms,
                               input bit tk, input bit sr, input bit sg);
        rst = r; start_btn = sb; mode_sel = ms;
        frame_tick = tk; shot_resolved = sr; shot_goal = sg;
        model_step(r, sb, ms, tk, sr, sg);
        @(posedge clk);
        exp_q.push_back(pack_exp());
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 1'($urandom), 0, 0, 0);
    endtask

    task automatic press_start(input bit ms);
        drive_cycle(0, 1, ms, 0, 0, 0);
    endtask

    // Hold ticks with a stray shot_resolved in the middle (must be dropped).
    task automatic hold_ticks();
        for (int i = 0; i < HOLD_FRAMES; i++) begin
            drive_cycle(0, 0, 1'($urandom), 1, 0, 0);
            if (i == 1) drive_cycle(0, 0, 1'($urandom), 0, 1, 1);
            else        idle(1);
        end
    endtask

    // p_mask bit k: player scores in round 2k; o_mask bit k: opponent in round 2k+1.
    task automatic play_game(input bit ms, input logic [5:0] p_mask,
                             input logic [5:0] o_mask, input int n_rounds);
        logic [5:0] pm, om;
        pm = p_mask; om = o_mask;
        press_start(ms);
        for (int r = 0; r < n_rounds; r++) begin
            if (r == 0) drive_cycle(0, 1, ~ms, 0, 0, 0);  // start during play
            else        idle(1);
            drive_cycle(0, 0, 1'($urandom), (r % 3 == 0),
                        1, (r % 2 == 0) ? pm[r/2] : om[r/2]);
            hold_ticks();
        end
        idle(2);
        press_start(1'($urandom));  // back to title screen
        idle(1);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] e, got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {game_state, game_mode, round_counter, score_player, score_opp, is_scored};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got gs=%0d mode=%0d rnd=%0d sp=%0d so=%0d sc=%0d, expected gs=%0d mode=%0d rnd=%0d sp=%0d so=%0d sc=%0d",
                             $time, got[W-1 -: 3], got[W-4], got[W-5 -: ROUND_W],
                             got[2*SCORE_W -: SCORE_W], got[SCORE_W:1], got[0],
                             e[W-1 -: 3], e[W-4], e[W-5 -: ROUND_W],
                             e[2*SCORE_W -: SCORE_W], e[SCORE_W:1], e[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; start_btn = 0; mode_sel = 0;
        frame_tick = 0; shot_resolved = 0; shot_goal = 0;
        @(posedge clk); #1;
        drive_cycle(1, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0);
        idle(2);

        // Ignored inputs on the title screen.
        drive_cycle(0, 0, 0, 1, 1, 1);

        // Score 3:2 after round 4's shot, then reset during the hold.
        press_start(1'b0);
        for (int r = 0; r < 5; r++) begin
            idle(1);
            drive_cycle(0, 0, 1, 0, 1, 1'(r != 4 || 1));
            if (r < 4) hold_ticks();
        end
        drive_cycle(0, 0, 0, 1, 0, 0);
        drive_cycle(1, 0, 0, 1, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0);
        idle(HOLD_FRAMES * 2);
        for (int i = 0; i < HOLD_FRAMES + 2; i++) drive_cycle(0, 0, 0, 1, 0, 0);

        play_game(1'b0, 6'b011111, 6'b000011, 10);  // 5:2 winner
        play_game(1'b1, 6'b000111, 6'b001111, 10);  // 3:4 looser
        play_game(1'b0, 6'b111111, 6'b011111, 12);  // 5:5, then 6:5 winner
        play_game(1'b1, 6'b011111, 6'b011111, 12);  // 5:5, both miss -> looser
        play_game(1'b0, 6'b101010, 6'b010101, 12);  // 2:3 looser after round 9
        for (int g = 0; g < 6; g++)
            play_game(1'($urandom), 6'($urandom), 6'($urandom), 12);

        // Random traffic.
        for (int i = 0; i < 20000; i++) begin
            drive_cycle(($urandom_range(0, 999) == 0),
                        ($urandom_range(0, 19) == 0),
                        1'($urandom),
                        ($urandom_range(0, 1) == 0),
                        ($urandom_range(0, 5) == 0),
                        1'($urandom));
        end
        idle(2);

        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
